// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment scan controller.
//   - Active-low segment patterns (bit order HGFEDCBA, H = decimal point).
//   - Slot phase enum used by the scan controller.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_INVALID = 8'h7F;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_bcd7seg.sv
// bcd7seg: combinational BCD to active-low 7-segment decoder.
//   bcd  in  4  BCD code
//   seg  out 8  HGFEDCBA, active-low; codes 10..15 give segments off, DP lit
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_INVALID;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with inter-digit blanking, per-digit
// decimal points, leading-zero suppression and frame-aligned updates.
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   load         in   request to replace display contents
//   value        in   4*NUM_DIGITS BCD digits, digit 0 rightmost
//   dp_mask      in   decimal point enable per digit
//   lz_blank     in   leading-zero suppression enable
//   seg          out  segments HGFEDCBA, active-low (registered)
//   an           out  anode enables, active-low (registered)
//   frame_start  out  high in cycle 0 of the digit-0 slot
//   load_ack     out  pulse when pending content becomes displayed
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    load_ack
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [VAL_W-1:0]      disp_value_q, disp_value_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  disp_lz_q, disp_lz_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  load_ack_q, load_ack_d;

  logic                  slot_end;
  logic                  transfer;
  phase_e                phase_d;
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_hi;
  logic [3:0]            dig_sel;
  logic                  dp_sel;
  logic                  supp_sel;
  logic [7:0]            dec_seg;

  // Prescaler, digit index and the pend/disp content registers.
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Transfer only on the edge that starts the digit-0 slot, and only for
    // content that was already pending before that edge.
    transfer     = slot_end && (idx_q == IDX_LAST) && pend_valid_q;

    disp_value_d = transfer ? pend_value_q : disp_value_q;
    disp_dp_d    = transfer ? pend_dp_q    : disp_dp_q;
    disp_lz_d    = transfer ? pend_lz_q    : disp_lz_q;

    // A load on the transfer edge refills pend and keeps it valid for the
    // next frame.
    pend_value_d = load ? value    : pend_value_q;
    pend_dp_d    = load ? dp_mask  : pend_dp_q;
    pend_lz_d    = load ? lz_blank : pend_lz_q;
    pend_valid_d = load | (pend_valid_q & ~transfer);

    load_ack_d   = transfer;
  end

  // Leading-zero suppression and digit mux, evaluated for the upcoming cycle
  // so the registered outputs line up with cnt/idx.
  always_comb begin
    supp    = '0;
    zero_hi = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_hi = zero_hi & (disp_value_d[4*i +: 4] == 4'd0);
      supp[i] = disp_lz_d & zero_hi;
    end

    dig_sel  = '0;
    dp_sel   = 1'b0;
    supp_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        dig_sel  = disp_value_d[4*i +: 4];
        dp_sel   = disp_dp_d[i];
        supp_sel = supp[i];
      end
    end
  end

  bcd7seg u_dec (
    .bcd (dig_sel),
    .seg (dec_seg)
  );

  // Output composition.
  always_comb begin
    phase_d = (cnt_d < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    seg_d   = SEG_BLANK;
    an_d    = '1;
    if (phase_d == PH_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_d != IDX_W'(i));
      end
      if (supp_sel) begin
        seg_d = {~dp_sel, 7'h7F};
      end else begin
        seg_d = {dec_seg[7] & ~dp_sel, dec_seg[6:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_lz_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      load_ack_q   <= load_ack_d;
    end
  end

  // frame_start is decoded from the counters; gating with rst keeps it low
  // while reset holds the counters at zero.
  assign frame_start = ~rst & (cnt_q == '0) & (idx_q == '0);
  assign seg         = seg_q;
  assign an          = an_q;
  assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with
// NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (frame = 32 cycles,
// digit d of a frame starting at F is driven from F+8d+2 to F+8d+7).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        load_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp_mask     (dp_mask),
    .lz_blank    (lz_blank),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start),
    .load_ack    (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to cycle k; samples happen on the falling edge.
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Hold reset for 3 rising edges, release it mid-cycle 0 and check cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    #1;
    cyc = 0;
    chk("c0_fs", 32'(frame_start), 32'h1);
    chk("c0_seg", 32'(seg), 32'hFF);
    chk("c0_an", 32'(an), 32'hF);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    load     = 1'b1;
    value    = v;
    dp_mask  = dp;
    lz_blank = lz;
  endtask

  // Check the DRIVE start of each digit in the frame starting at cycle f.
  task automatic chk_frame(input string tag, input int f,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    exp_an[0] = 4'hE; exp_an[1] = 4'hD; exp_an[2] = 4'hB; exp_an[3] = 4'h7;
    for (int d = 0; d < 4; d++) begin
      go_to(f + 8*d + 2);
      chk($sformatf("%s_an%0d", tag, d), 32'(an), 32'(exp_an[d]));
      chk($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(exp_seg[d]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_cnt;
    int f9_cnt;
    load     = 1'b0;
    value    = '0;
    dp_mask  = '0;
    lz_blank = 1'b0;

    // 1. Reset and the first digit slot.
    do_reset();
    chk("c0_ack", 32'(load_ack), 32'h0);
    go_to(1);
    chk("c1_an", 32'(an), 32'hF);
    chk("c1_fs", 32'(frame_start), 32'h0);
    for (int c = 2; c <= 7; c++) begin
      go_to(c);
      chk("t1_an", 32'(an), 32'hE);
      chk("t1_seg", 32'(seg), 32'hC0);
    end
    go_to(8);
    chk("t1_c8_an", 32'(an), 32'hF);

    // 2. Load with decimal point during frame 0, sampled at the edge of cycle 10.
    go_to(9);
    do_load(16'h1234, 4'b0100, 1'b0);
    go_to(10);
    load = 1'b0;
    go_to(31);
    chk("t2_ack31", 32'(load_ack), 32'h0);
    go_to(32);
    chk("t2_ack32", 32'(load_ack), 32'h1);
    chk("t2_fs32", 32'(frame_start), 32'h1);
    chk("t2_seg32", 32'(seg), 32'hFF);
    go_to(33);
    chk("t2_ack33", 32'(load_ack), 32'h0);
    chk_frame("t2", 32, 8'h99, 8'hB0, 8'h24, 8'hF9);

    // 3. Leading-zero blanking.
    do_load(16'h0050, 4'b0000, 1'b1);
    go_to(59);
    load = 1'b0;
    go_to(64);
    chk("t3_ack", 32'(load_ack), 32'h1);
    chk_frame("t3", 64, 8'hC0, 8'h92, 8'hFF, 8'hFF);

    // 4. Invalid code on digit 0 with its decimal point.
    do_load(16'h000A, 4'b0001, 1'b1);
    go_to(91);
    load = 1'b0;
    go_to(96);
    chk("t4_ack", 32'(load_ack), 32'h1);
    chk_frame("t4", 96, 8'h7F, 8'hFF, 8'hFF, 8'hFF);

    // 5. Double load within one frame: latest wins, one ack.
    do_load(16'h1111, 4'b0000, 1'b0);
    go_to(123);
    do_load(16'h2222, 4'b0000, 1'b0);
    go_to(124);
    load = 1'b0;
    go_to(127);
    chk("t5_ack127", 32'(load_ack), 32'h0);
    ack_cnt = 0;
    f9_cnt  = 0;
    for (int c = 128; c <= 159; c++) begin
      go_to(c);
      if (load_ack) ack_cnt++;
      if (seg == 8'hF9) f9_cnt++;
      if ((c - 128) % 8 == 2) chk("t5_seg", 32'(seg), 32'hA4);
      if (c == 150) do_load(16'h3333, 4'b0000, 1'b0);
      if (c == 151) load = 1'b0;
      if (c == 159) do_load(16'h4444, 4'b0000, 1'b0);
    end
    chk("t5_ack_count", 32'(ack_cnt), 32'h1);
    chk("t5_no_f9", 32'(f9_cnt), 32'h0);

    // Load 4444 lands on the transfer edge of cycle 160 while 3333 transfers.
    go_to(160);
    load = 1'b0;
    chk("t5_ack160", 32'(load_ack), 32'h1);
    chk("t5_fs160", 32'(frame_start), 32'h1);
    go_to(162);
    chk("t5_seg162", 32'(seg), 32'hB0);
    go_to(186);
    chk("t5_an186", 32'(an), 32'h7);
    chk("t5_seg186", 32'(seg), 32'hB0);
    go_to(191);
    chk("t5_ack191", 32'(load_ack), 32'h0);
    go_to(192);
    chk("t5_ack192", 32'(load_ack), 32'h1);
    go_to(194);
    chk("t5_seg194", 32'(seg), 32'h99);
    chk("t5_an194", 32'(an), 32'hE);

    // 6. Reset mid-operation with a pending load.
    do_reset();
    go_to(5);
    do_load(16'h5555, 4'b1111, 1'b0);
    go_to(6);
    load = 1'b0;
    go_to(13);
    chk("t6_an13", 32'(an), 32'hD);
    chk("t6_seg13", 32'(seg), 32'hC0);
    rst = 1'b1;
    go_to(14);
    chk("t6_seg14", 32'(seg), 32'hFF);
    chk("t6_an14", 32'(an), 32'hF);
    chk("t6_ack14", 32'(load_ack), 32'h0);
    go_to(15);
    rst = 1'b0;
    #1;
    cyc = 0;
    chk("t6_fs0", 32'(frame_start), 32'h1);
    ack_cnt = 0;
    for (int c = 0; c <= 63; c++) begin
      go_to(c);
      if (load_ack) ack_cnt++;
      if (c == 2 || c == 34) begin
        chk("t6_an", 32'(an), 32'hE);
        chk("t6_seg", 32'(seg), 32'hC0);
      end
    end
    chk("t6_no_ack", 32'(ack_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
